// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, default geometry
// and the instruction word that stops fetching.
package if_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } if_state_e;

    localparam int unsigned XLEN_DEFAULT     = 5;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
    localparam logic [31:0] HALT_WORD        = 32'h0;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: walks a 2**XLEN-byte instruction space, hands words to
// decode through a valid/ready register, stops on an all-zero word, obeys redirects.
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        halted_o,
    output logic        misalign_o
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_RESET = RESET_PC[XLEN-1:0];

    if_state_e       state_q;
    logic            halted_q;
    logic            misalign_q;

    logic [XLEN-1:0] pc_q,      pc_d;
    logic            id_vld_q,  id_vld_d;
    logic [31:0]     id_pc_q,   id_pc_d;
    logic [31:0]     id_inst_q, id_inst_d;

    logic            redirect_act;
    logic            redirect_ok;
    logic            fire;
    logic            zero_word;

    // Only the low XLEN bits of a redirect target address the fetch space.
    generate
        if (XLEN < 32) begin : g_hi_bits
            logic unused_redirect_hi;
            assign unused_redirect_hi = ^redirect_pc_i[31:XLEN];
        end
    endgenerate

    assign imem_addr_o = 32'(pc_q);

    // Redirect wins over stall and halt detection; it is ignored in BOOT and FAULT.
    assign redirect_act = redirect_i && ((state_q == ST_RUN) || (state_q == ST_HALT));
    assign redirect_ok  = word_aligned(redirect_pc_i);
    assign fire         = (state_q == ST_RUN) && !redirect_i && (!id_vld_q || id_ready_i);
    assign zero_word    = (imem_data_i == HALT_WORD);

    always_comb begin
        pc_d      = pc_q;
        id_vld_d  = id_vld_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        if (redirect_act) begin
            id_vld_d = 1'b0;
            if (redirect_ok) begin
                pc_d = redirect_pc_i[XLEN-1:0];
            end
        end else if (fire) begin
            if (!zero_word) begin
                id_pc_d   = imem_addr_o;
                id_inst_d = imem_data_i;
                id_vld_d  = 1'b1;
                pc_d      = pc_q + PC_STEP;
            end else begin
                id_vld_d  = 1'b0;
            end
        end else if (id_vld_q && id_ready_i) begin
            id_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= PC_RESET;
            id_vld_q  <= 1'b0;
            id_pc_q   <= 32'h0;
            id_inst_q <= 32'h0;
        end else begin
            pc_q      <= pc_d;
            id_vld_q  <= id_vld_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                end
                ST_RUN, ST_HALT: begin
                    if (redirect_i) begin
                        halted_q <= 1'b0;
                        if (redirect_ok) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q    <= ST_FAULT;
                            misalign_q <= 1'b1;
                        end
                    end else if (fire && zero_word) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q  <= ST_BOOT;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign id_valid_o = id_vld_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign halted_o   = halted_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: combinational instruction memory model and a
// scoreboard of (pc, inst) pairs checked on every decode handshake.
module tb_if_stage;

    localparam int unsigned XLEN = 5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        halted;
    logic        misalign;

    logic [31:0] mem [0:7];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    if_stage #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .id_valid_o   (id_valid),
        .id_ready_i   (id_ready),
        .id_pc_o      (id_pc),
        .id_inst_o    (id_inst),
        .halted_o     (halted),
        .misalign_o   (misalign)
    );

    assign imem_data = mem[imem_addr[XLEN-1:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Handshake is judged just before the edge, with inputs already settled.
    task automatic step();
        exp_t e;
        if (id_valid && id_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=pc %h inst %h expected=no output", id_pc, id_inst);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_pc", id_pc, e.pc);
                chk("sb_inst", id_inst, e.inst);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        sb.push_back(e);
    endtask

    initial begin
        mem[0] = 32'h01000413;
        mem[1] = 32'h10100493;
        mem[2] = 32'h00848933;
        mem[3] = 32'h00000000;
        mem[4] = 32'h00000013;
        mem[5] = 32'h00000013;
        mem[6] = 32'h00000013;
        mem[7] = 32'h00000013;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;

        @(negedge clk);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_inst", id_inst, 0);
        chk("rst_halted", halted, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_addr", imem_addr, 32'h0);

        // Straight-line run to the zero word.
        rst_n = 1'b1;
        push(32'h00, 32'h01000413);
        push(32'h04, 32'h10100493);
        push(32'h08, 32'h00848933);
        step();
        chk("boot_no_valid", id_valid, 0);
        step();
        chk("first_valid", id_valid, 1);
        chk("first_pc", id_pc, 32'h00);
        step();
        step();
        step();
        chk("s1_halted", halted, 1);
        chk("s1_valid", id_valid, 0);
        chk("s1_addr_hold", imem_addr, 32'h0C);
        step();
        chk("halt_stays", halted, 1);
        chk("halt_addr", imem_addr, 32'h0C);

        // Redirect out of HALT, then stall on the redirected word.
        redirect    = 1'b1;
        redirect_pc = 32'h04;
        id_ready    = 1'b0;
        step();
        redirect = 1'b0;
        chk("s3_valid_drop", id_valid, 0);
        chk("s3_halted_clr", halted, 0);
        chk("s3_addr", imem_addr, 32'h04);
        push(32'h04, 32'h10100493);
        step();
        chk("s3_valid", id_valid, 1);
        chk("s3_pc", id_pc, 32'h04);
        chk("s3_inst", id_inst, 32'h10100493);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s2_hold_valid", id_valid, 1);
            chk("s2_hold_pc", id_pc, 32'h04);
            chk("s2_hold_inst", id_inst, 32'h10100493);
            chk("s2_hold_addr", imem_addr, 32'h08);
        end
        id_ready = 1'b1;
        push(32'h08, 32'h00848933);
        step();
        chk("s2_resume_pc", id_pc, 32'h08);
        step();
        chk("s2_halted", halted, 1);
        chk("s2_valid", id_valid, 0);

        // Redirect to the last word of the space; the address must wrap.
        redirect    = 1'b1;
        redirect_pc = 32'h1C;
        step();
        redirect = 1'b0;
        chk("s5_addr", imem_addr, 32'h1C);
        chk("s5_valid_drop", id_valid, 0);
        push(32'h1C, 32'h00000013);
        step();
        chk("s5_pc", id_pc, 32'h1C);
        chk("s5_wrap_addr", imem_addr, 32'h00);
        push(32'h00, 32'h01000413);
        push(32'h04, 32'h10100493);
        push(32'h08, 32'h00848933);
        step();
        step();
        step();
        id_ready = 1'b0;
        step();
        chk("s6_stall_valid", id_valid, 1);
        chk("s6_stall_pc", id_pc, 32'h08);

        // Reset while stalled drops the held word at once.
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", id_valid, 0);
        chk("s6_rst_pc", id_pc, 0);
        chk("s6_rst_inst", id_inst, 0);
        chk("s6_rst_addr", imem_addr, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        id_ready = 1'b1;
        push(32'h00, 32'h01000413);
        step();
        step();
        chk("s6_restart_pc", id_pc, 32'h00);
        step();
        chk("s6_next_pc", id_pc, 32'h04);

        // Misaligned redirect while a word is held and stalled.
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h06;
        step();
        redirect = 1'b0;
        id_ready = 1'b1;
        chk("s4_misalign", misalign, 1);
        chk("s4_valid", id_valid, 0);
        chk("s4_addr_hold", imem_addr, 32'h08);
        chk("s4_halted", halted, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_fault_valid", id_valid, 0);
            chk("s4_fault_sticky", misalign, 1);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h04;
        step();
        redirect = 1'b0;
        chk("s4_ignored_valid", id_valid, 0);
        chk("s4_ignored_addr", imem_addr, 32'h08);
        chk("s4_ignored_flag", misalign, 1);
        step();
        chk("s4_ignored_later", id_valid, 0);

        rst_n = 1'b0;
        #1;
        chk("s4_rst_misalign", misalign, 0);
        chk("s4_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h00, 32'h01000413);
        step();
        step();
        chk("s4_restart_valid", id_valid, 1);
        chk("s4_restart_pc", id_pc, 32'h00);
        step();

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter XLEN, default 5, SHALL set the instruction-memory address width in bits; the fetch space is 2**XLEN bytes.
REQ-002 Parameter RESET_PC, default 32'h0, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr_o  output  32  byte address driven to the combinational instruction memory.
REQ-006 imem_data_i  input  32  little-endian instruction word returned in the same cycle for imem_addr_o.
REQ-007 redirect_i  input  1  branch/jump redirect request from a later stage.
REQ-008 redirect_pc_i  input  32  redirect target address.
REQ-009 id_valid_o  output  1  id_pc_o and id_inst_o hold an instruction for decode.
REQ-010 id_ready_i  input  1  decode accepts the held instruction this cycle.
REQ-011 id_pc_o  output  32  address of the held instruction.
REQ-012 id_inst_o  output  32  the held instruction word.
REQ-013 halted_o  output  1  fetch stopped on an all-zero word.
REQ-014 misalign_o  output  1  sticky flag for a redirect target that is not word-aligned.

Function
REQ-015 imem_addr_o SHALL equal pc_q combinationally, where pc_q is the next fetch address.
REQ-016 The FSM SHALL have the states BOOT, RUN, HALT and FAULT. BOOT SHALL move to RUN unconditionally one cycle after reset release, and no fetch SHALL occur in BOOT.
REQ-017 A fetch SHALL fire when the state is RUN, redirect_i=0, and either id_valid_o=0 or id_ready_i=1.
REQ-018 When a fetch fires on a nonzero imem_data_i, the stage SHALL set id_pc_o<=pc_q, id_inst_o<=imem_data_i and id_valid_o<=1, giving a latency of one cycle from address to decode output.
REQ-019 On that same fire, pc_q SHALL advance to (pc_q+4) mod 2**XLEN, with bits 31:XLEN held at zero.
REQ-020 When id_valid_o=1 and id_ready_i=0, id_pc_o, id_inst_o, id_valid_o and pc_q SHALL hold unchanged.
REQ-021 When id_valid_o=1, id_ready_i=1 and no fetch fires, id_valid_o SHALL go to 0 at the next edge.
REQ-022 When a fetch fires on imem_data_i=32'h0, the word SHALL NOT be presented, id_valid_o SHALL follow REQ-021, pc_q SHALL hold, and the state SHALL go to HALT.
REQ-023 halted_o SHALL be 1 exactly while the state is HALT.
REQ-024 Redirect priority: redirect_i=1 SHALL override every other event in the same cycle, including stall and zero-word detection.
REQ-025 A redirect with redirect_pc_i[1:0]=0 SHALL set pc_q<=redirect_pc_i mod 2**XLEN and id_valid_o<=0 at the next edge.
REQ-026 That aligned redirect SHALL move the state from RUN or HALT to RUN, so the first post-redirect fetch fires on the next cycle.
REQ-027 A redirect with redirect_pc_i[1:0]!=0 SHALL set misalign_o<=1, id_valid_o<=0 and state<=FAULT, and pc_q SHALL hold.
REQ-028 In FAULT, redirect_i SHALL be ignored; only reset exits FAULT.
REQ-029 id_pc_o and id_inst_o SHALL change only on a fire or on reset.

Reset
REQ-030 While rst_n=0, the stage SHALL hold state=BOOT, pc_q=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0, halted_o=0 and misalign_o=0, asynchronously.
REQ-031 Reset asserted mid-operation, including during a stall, HALT or FAULT, SHALL discard any held instruction, and after release the output sequence SHALL restart from RESET_PC.

Structure
REQ-032 A shared package if_pkg SHALL hold the FSM state enum, the default XLEN, RESET_PC and the HALT_WORD constant (32'h0).
REQ-033 The stage SHALL be a single module with no sub-module. The instruction memory SHALL remain external and connect through imem_addr_o/imem_data_i.

Verification
REQ-034 Bench instruction memory: words 0x01000413@0x00, 0x10100493@0x04, 0x00848933@0x08, 0x00000000@0x0C.
REQ-035 Scenario 1: release reset with id_ready_i=1 -> (0x00, 0x01000413), (0x04, 0x10100493) and (0x08, 0x00848933) are presented on consecutive cycles starting two edges after release, then halted_o=1 and id_valid_o=0.
REQ-036 Scenario 2: id_ready_i=0 for 3 cycles while 0x10100493 is held -> all outputs stay stable and imem_addr_o stays 0x08; raising ready resumes with 0x00848933.
REQ-037 Scenario 3: in HALT, redirect to 0x04 -> id_valid_o=0 on the next edge, then (0x04, 0x10100493) is presented and halted_o=0.
REQ-038 Scenario 4: redirect to 0x06 -> misalign_o=1, state FAULT, no further valid output; a later aligned redirect is ignored and reset clears the fault.
REQ-039 Scenario 5: memory 0x1C=0x00000013 and redirect to 0x1C -> (0x1C, 0x00000013) is presented and the next imem_addr_o is 0x00.
REQ-040 Scenario 6: rst_n pulsed low while stalled on 0x00848933 -> id_valid_o=0 immediately, then the sequence restarts from 0x00.
